deque_ring: RTL
===============

# deque_ring

Parametrised double-ended queue on a circular buffer. It is the successor to the per-channel LIFO: configurable data width and depth, with push and pop at both ends. It sits behind the same channel-select bus, so several instances share one set of command and data lines and only the addressed instance acts. It also adds an occupancy count and sticky overflow and underflow flags.

## Interface
- WIDTH, default 8: data word width in bits.
- WORDS, default 16: capacity in words; must be a power of two and ≥2.
- SEL_BITS, default 1: width of the channel-select bus.
- ADDR, default 0: select value this instance answers to.
- clk, input, 1: clock.
- rst_n, input, 1: reset, synchronous, active-low.
- sel, input, SEL_BITS: channel select; the instance is active when sel == ADDR.
- push_front, input, 1: insert data_in ahead of the current front.
- push_back, input, 1: insert data_in behind the current back.
- pop_front, input, 1: remove the front element.
- pop_back, input, 1: remove the back element.
- data_in, input, WIDTH: write data.
- data_front, output, WIDTH: front element; 0 when empty or not selected.
- data_back, output, WIDTH: back element; 0 when empty or not selected.
- empty, output, 1: count == 0.
- full, output, 1: count == WORDS.
- count, output, $clog2(WORDS+1): occupancy.
- ovf, output, 1: sticky flag; a push was attempted while full.
- unf, output, 1: sticky flag; a pop was attempted while empty.

## Operation
- Storage is an array mem[WORDS] of WIDTH bits.
- head is the index of the front element. tail is the index one past the back element.
- Both pointers are $clog2(WORDS) bits wide and wrap modulo WORDS through natural overflow.
- When sel != ADDR, all command inputs are ignored and no state changes, including the flags.
- When selected, at most one command executes per cycle. Fixed priority: push_front > push_back > pop_front > pop_back. Lower-priority commands asserted in the same cycle are dropped silently, with no flag.
- push_front, not full: mem[head-1] <= data_in; head <= head-1; count += 1.
- push_back, not full: mem[tail] <= data_in; tail <= tail+1; count += 1.
- pop_front, not empty: head <= head+1; count -= 1. Memory is not cleared.
- pop_back, not empty: tail <= tail-1; count -= 1.
- Push while full: no state change except ovf <= 1.
- Pop while empty: no state change except unf <= 1.
- data_front = mem[head] and data_back = mem[tail-1], both combinational. With one element, both outputs show the same word.
- empty, full and count are derived from the count register. head == tail is ambiguous between empty and full and is never used for that decision.

## Timing
- Reset, checked at the clock edge while rst_n = 0:
  - head = tail = 0, count = 0.
  - All mem words = 0, ovf = unf = 0.
  - Outputs: empty = 1, full = 0, data_front = data_back = 0.
- Reset has priority over any command in the same cycle. A command issued mid-operation during reset is discarded.
- Every command takes effect at the rising edge it is sampled on. The updated data and flags are visible combinationally right after that edge (1-cycle latency).
- Wrap-around:
  - push_front at head = 0 writes mem[WORDS-1].
  - pop_back at tail = 0 moves tail to WORDS-1.
- ovf and unf stay at 1 until the next reset.

## Structure
- Package deque_pkg holds:
  - the command enum deque_cmd_t: CMD_NONE, CMD_PUSH_F, CMD_PUSH_B, CMD_POP_F, CMD_POP_B;
  - the function deque_decode(push_front, push_back, pop_front, pop_back), which implements the priority.
- One sub-module, deque_ring_mem: WORDS×WIDTH storage with a synchronous clear-on-reset, one write port, and two asynchronous read ports (front and back).
- Pointer and count logic stays in deque_ring.

## Test plan
- Reset, then idle: empty = 1, count = 0, data_front = data_back = 0, ovf = unf = 0.
- WORDS = 4, selected:
  - push_back 0x11, 0x22, then push_front 0x33 → data_front = 0x33, data_back = 0x22, count = 3.
  - pop_back → data_back = 0x11.
  - pop_front → data_front = 0x11, count = 1.
- WORDS = 4, from reset: push_front 0xA0 (head wraps to 3). Push_back 0xB0, 0xC0, 0xD0 → full = 1.
  - A further push_back 0xEE → ovf = 1, contents unchanged.
  - Four pop_front → 0xA0, 0xB0, 0xC0, 0xD0 in order, then empty = 1.
  - A further pop_front → unf = 1.
- All four commands asserted together with data_in = 0x5A and count = 1 → only push_front executes: count = 2, data_front = 0x5A.
- Two instances with ADDR = 0 and ADDR = 1 on a shared bus, sel = 1, push_back 0x77:
  - Instance 1 gets count = 1.
  - Instance 0 is unchanged and drives data_front = 0.
- Fill to count = 3, then assert rst_n = 0 together with push_back for one cycle → count = 0, empty = 1, all mem words 0.

Source files
------------

// File: rtl/deque_pkg.sv
// Shared types and command priority decode for the channel-selected ring deque.
package deque_pkg;

   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_PUSH_F,
      CMD_PUSH_B,
      CMD_POP_F,
      CMD_POP_B
   } deque_cmd_t;

   // One command per cycle; lower-priority requests in the same cycle are dropped.
   function automatic deque_cmd_t deque_decode(input logic push_front,
                                               input logic push_back,
                                               input logic pop_front,
                                               input logic pop_back);
      if (push_front)     return CMD_PUSH_F;
      else if (push_back) return CMD_PUSH_B;
      else if (pop_front) return CMD_POP_F;
      else if (pop_back)  return CMD_POP_B;
      else                return CMD_NONE;
   endfunction

endpackage

// File: rtl/deque_ring_mem.sv
// WORDS x WIDTH storage: one write port, asynchronous front/back read ports,
// every word cleared while rst_n is low.
module deque_ring_mem #(
   parameter int  WIDTH = 8,
   parameter int  WORDS = 16,
   localparam int PTR_W = $clog2(WORDS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PTR_W-1:0] raddr_front,
   input  logic [PTR_W-1:0] raddr_back,
   output logic [WIDTH-1:0] rdata_front,
   output logic [WIDTH-1:0] rdata_back
);

   logic [WIDTH-1:0] mem_q [WORDS];
   logic [WIDTH-1:0] mem_d [WORDS];

   // NOTE: always_comb uses blocking '=' and starts from a full default, so no latch is inferred.
   always_comb begin
      mem_d = mem_q;
      if (we) mem_d[waddr] = wdata;
   end

   // NOTE: the storage is deliberately reset word by word; the outputs must read 0 after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < WORDS; i++) mem_q[i] <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rdata_front = mem_q[raddr_front];
   assign rdata_back  = mem_q[raddr_back];

endmodule

// File: rtl/deque_ring.sv
// Double-ended queue on a circular buffer behind a shared channel-select bus,
// with occupancy count and sticky overflow/underflow flags.
module deque_ring
   import deque_pkg::*;
#(
   parameter int  WIDTH    = 8,
   parameter int  WORDS    = 16,
   parameter int  SEL_BITS = 1,
   parameter int  ADDR     = 0,
   localparam int PTR_W    = $clog2(WORDS),
   localparam int CNT_W    = $clog2(WORDS + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SEL_BITS-1:0] sel,
   input  logic                push_front,
   input  logic                push_back,
   input  logic                pop_front,
   input  logic                pop_back,
   input  logic [WIDTH-1:0]    data_in,
   output logic [WIDTH-1:0]    data_front,
   output logic [WIDTH-1:0]    data_back,
   output logic                empty,
   output logic                full,
   output logic [CNT_W-1:0]    count,
   output logic                ovf,
   output logic                unf
);

   localparam logic [SEL_BITS-1:0] MY_ADDR  = SEL_BITS'(ADDR);
   localparam logic [PTR_W-1:0]    PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(WORDS);

   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;
   logic             active, mem_we;
   logic [PTR_W-1:0] mem_waddr, back_idx;
   logic [WIDTH-1:0] rd_front, rd_back;
   deque_cmd_t       cmd;

   assign active   = (sel == MY_ADDR);
   assign cmd      = active ? deque_decode(push_front, push_back, pop_front, pop_back) : CMD_NONE;
   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_FULL);
   assign back_idx = tail_q - PTR_ONE;

   always_comb begin
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      mem_we    = 1'b0;
      mem_waddr = tail_q;
      unique case (cmd)
         CMD_PUSH_F: begin
            if (full) begin
               ovf_d = 1'b1;
            end else begin
               mem_we    = 1'b1;
               mem_waddr = head_q - PTR_ONE;
               head_d    = head_q - PTR_ONE;
               count_d   = count_q + CNT_ONE;
            end
         end
         CMD_PUSH_B: begin
            if (full) begin
               ovf_d = 1'b1;
            end else begin
               mem_we  = 1'b1;
               tail_d  = tail_q + PTR_ONE;
               count_d = count_q + CNT_ONE;
            end
         end
         CMD_POP_F: begin
            if (empty) begin
               unf_d = 1'b1;
            end else begin
               head_d  = head_q + PTR_ONE;
               count_d = count_q - CNT_ONE;
            end
         end
         CMD_POP_B: begin
            if (empty) begin
               unf_d = 1'b1;
            end else begin
               tail_d  = tail_q - PTR_ONE;
               count_d = count_q - CNT_ONE;
            end
         end
         default: ;
      endcase
   end

   // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   deque_ring_mem #(.WIDTH(WIDTH), .WORDS(WORDS)) u_mem (
      .clk         (clk),
      .rst_n       (rst_n),
      .we          (mem_we),
      .waddr       (mem_waddr),
      .wdata       (data_in),
      .raddr_front (head_q),
      .raddr_back  (back_idx),
      .rdata_front (rd_front),
      .rdata_back  (rd_back)
   );

   // Data outputs are gated so unselected instances on the shared bus read as 0.
   assign data_front = (active && !empty) ? rd_front : '0;
   assign data_back  = (active && !empty) ? rd_back  : '0;
   assign count      = count_q;
   assign ovf        = ovf_q;
   assign unf        = unf_q;

endmodule
